// File: rtl/edge_event_arbiter.sv
// Per-channel edge detector with configurable edge mode, pending/overflow latches,
// and a round-robin drain onto a single valid/ready event port.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [NUM_CH-1:0] ovf_clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_type,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overflow
);

  // Handshake: an event transfers on a cycle where evt_valid && evt_ready;
  // while evt_valid && !evt_ready, evt_valid/evt_ch/evt_type hold unchanged.

  logic [NUM_CH-1:0]      prev_q, prev_d;
  logic [NUM_CH-1:0][1:0] mode_q, mode_d;
  logic [NUM_CH-1:0]      pending_q, pending_d;
  logic [NUM_CH-1:0]      ptype_q, ptype_d;
  logic [NUM_CH-1:0]      overflow_q, overflow_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]        evt_ch_q, evt_ch_d;
  logic                   evt_type_q, evt_type_d;
  logic [CH_W-1:0]        rr_q, rr_d;

  logic [NUM_CH-1:0] rise, fall, rise_en, fall_en, qual;
  logic              slot_free;
  logic              cfg_in_range;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_type;
  logic              found_hi, found_lo;
  logic [CH_W-1:0]   hi_ch, lo_ch;
  logic              hi_type, lo_type;

  always_comb begin
    rise_en = '0;
    fall_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rise_en[i] = mode_q[i][0];
      fall_en[i] = mode_q[i][1];
    end
    rise = sig_in & ~prev_q;
    fall = ~sig_in & prev_q;
    qual = (rise & rise_en) | (fall & fall_en);
  end

  // Round-robin: lowest pending channel above rr wins, else lowest at/below rr.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    hi_type  = 1'b0;
    lo_type  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pending_q[i]) begin
        if (CH_W'(i) > rr_q) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            hi_ch    = CH_W'(i);
            hi_type  = ptype_q[i];
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          lo_ch    = CH_W'(i);
          lo_type  = ptype_q[i];
        end
      end
    end
    slot_free  = !evt_valid_q || evt_ready;
    grant_vld  = slot_free && (found_hi || found_lo);
    grant_ch   = found_hi ? hi_ch : lo_ch;
    grant_type = found_hi ? hi_type : lo_type;
  end

  always_comb begin
    prev_d       = sig_in;
    mode_d       = mode_q;
    pending_d    = pending_q;
    ptype_d      = ptype_q;
    overflow_d   = overflow_q & ~ovf_clr;
    evt_valid_d  = evt_valid_q;
    evt_ch_d     = evt_ch_q;
    evt_type_d   = evt_type_q;
    rr_d         = rr_q;
    cfg_in_range = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));

    if (slot_free) begin
      evt_valid_d = grant_vld;
      if (grant_vld) begin
        evt_ch_d   = grant_ch;
        evt_type_d = grant_type;
        rr_d       = grant_ch;
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_vld && (grant_ch == CH_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      // A new edge on a channel still holding an un-granted event is dropped.
      if (qual[i]) begin
        if (pending_q[i] && !(grant_vld && (grant_ch == CH_W'(i)))) begin
          overflow_d[i] = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          ptype_d[i]   = rise[i];
        end
      end
      if (cfg_we && cfg_in_range && (cfg_ch == CH_W'(i))) begin
        mode_d[i] = cfg_mode;
        if (cfg_mode == 2'b00) begin
          pending_d[i]  = 1'b0;
          overflow_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= sig_in;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= 2'b01;
      end
      pending_q   <= '0;
      ptype_q     <= '0;
      overflow_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_type_q  <= 1'b0;
      rr_q        <= CH_W'(NUM_CH-1);
    end else begin
      prev_q      <= prev_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      ptype_q     <= ptype_d;
      overflow_q  <= overflow_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_type_q  <= evt_type_d;
      rr_q        <= rr_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_type  = evt_type_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
